idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage RISC-V core, replacing the fixed-width free-running latch.
- Adds a valid bit, external stall (hold), flush (bubble), and built-in load-use hazard detection with automatic bubble insertion.
- Adds saturating stall and bubble event counters for performance debug.
- Sits between the decode/register-file stage and the EX stage; hazard_o drives the PC and IF/ID write-enables.

Parameters:
- DATA_W, 32, width of data1/data2/imm datapath fields
- REG_AW, 5, register address width
- FUNCT_W, 10, width of funct field ({funct7, funct3})
- ALUOP_W, 2, width of ALUOp
- COUNT_W, 16, width of each event counter

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold all registered contents this cycle
- flush_i  in  1  load a bubble this cycle (branch taken / exception)
- valid_i  in  1  decode stage holds a real instruction
- use_rs1_i, use_rs2_i  in  1 each  decode instruction actually reads rs1 / rs2
- ALUOp_i  in  ALUOP_W  ALU operation class
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits
- data1_i, data2_i, imm_i  in  DATA_W each  signed operands and immediate
- funct_i  in  FUNCT_W  funct field
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW each  register addresses
- ALUOp_o ... RDaddr_o  out  same widths  registered copies of each matching *_i
- valid_o  out  1  EX stage holds a real instruction
- hazard_o  out  1  load-use hazard; upstream must hold PC and IF/ID
- stall_cnt_o  out  COUNT_W  cycles with stall_i honoured
- bubble_cnt_o  out  COUNT_W  bubbles inserted by load-use detection

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: on a clk_i edge with rst_i=1, every output register is 0, including valid_o and both counters.
- Latency: 1 cycle input-to-output on a normal load.
- Field mapping: each *_o loads its own *_i; data2_o loads data2_i.
- Raw hazard: raw_hz = valid_o & MemRead_o & (RDaddr_o != 0) & valid_i & ((use_rs1_i & RS1addr_i==RDaddr_o) | (use_rs2_i & RS2addr_i==RDaddr_o)).
- hazard_o: combinational, equal to raw_hz & ~flush_i.
- Per-edge priority, highest first:
  1. rst_i: clear everything.
  2. flush_i: bubble. All fields and valid_o become 0. Counters unchanged. Flush overrides stall_i.
  3. stall_i: all fields and valid_o hold. stall_cnt_o increments. hazard_o still reported, no bubble inserted.
  4. raw_hz: bubble as in 2. bubble_cnt_o increments.
  5. Otherwise: normal load, with valid_o <= valid_i.
- Bubble content: all control bits 0, so no RegWrite and no memory access. Datapath fields are also 0 for deterministic traces.
- After a hazard bubble, valid_o=0, so raw_hz deasserts the next cycle and the held instruction loads. Each load-use pair costs exactly 1 bubble.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-hazard takes effect on that edge. The next cycle starts from the empty state.

Test Plan:
- Reset then single load: rst_i 2 cycles, then valid_i=1, RDaddr_i=5, data1_i=0x11, data2_i=0x22, RegWrite_i=1 -> next cycle RDaddr_o=5, data1_o=0x11, data2_o=0x22, RegWrite_o=1, valid_o=1, hazard_o=0.
- Load-use: EX holds lw x7 (MemRead_o=1, RDaddr_o=7); decode add x1,x7,x2 with use_rs1_i=1 -> hazard_o=1. Next edge: valid_o=0, MemRead_o=0, bubble_cnt_o=1. Following edge: add loaded, valid_o=1.
- No false hazard: lw x0 in EX, or RS2addr_i=7 with use_rs2_i=0 -> hazard_o=0 and no bubble.
- Stall with flush: 3 cycles stall_i=1 -> outputs held, stall_cnt_o=3. Then stall_i=1 and flush_i=1 together -> bubble loaded, stall_cnt_o stays 3, hazard_o=0.
- Saturation: COUNT_W=2, stall_i held 6 cycles -> stall_cnt_o reads 1,2,3,3,3,3.
- Reset mid-hazard: hazard_o=1 with rst_i pulsed -> all outputs 0 next cycle, counters 0, hazard_o=0.

Source files
------------

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control, load-use hazard
// detection with automatic single-bubble insertion, and saturating event counters.
module idex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 10,
  parameter int ALUOP_W = 2,
  parameter int COUNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic                     use_rs1_i,
  input  logic                     use_rs2_i,
  input  logic [ALUOP_W-1:0]       ALUOp_i,
  input  logic                     ALUSrc_i,
  input  logic                     RegWrite_i,
  input  logic                     MemtoReg_i,
  input  logic                     MemRead_i,
  input  logic                     MemWrite_i,
  input  logic signed [DATA_W-1:0] data1_i,
  input  logic signed [DATA_W-1:0] data2_i,
  input  logic signed [DATA_W-1:0] imm_i,
  input  logic [FUNCT_W-1:0]       funct_i,
  input  logic [REG_AW-1:0]        RS1addr_i,
  input  logic [REG_AW-1:0]        RS2addr_i,
  input  logic [REG_AW-1:0]        RDaddr_i,
  output logic [ALUOP_W-1:0]       ALUOp_o,
  output logic                     ALUSrc_o,
  output logic                     RegWrite_o,
  output logic                     MemtoReg_o,
  output logic                     MemRead_o,
  output logic                     MemWrite_o,
  output logic signed [DATA_W-1:0] data1_o,
  output logic signed [DATA_W-1:0] data2_o,
  output logic signed [DATA_W-1:0] imm_o,
  output logic [FUNCT_W-1:0]       funct_o,
  output logic [REG_AW-1:0]        RS1addr_o,
  output logic [REG_AW-1:0]        RS2addr_o,
  output logic [REG_AW-1:0]        RDaddr_o,
  output logic                     valid_o,
  output logic                     hazard_o,
  output logic [COUNT_W-1:0]       stall_cnt_o,
  output logic [COUNT_W-1:0]       bubble_cnt_o
);

  typedef struct packed {
    logic                 valid;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 alu_src;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_read;
    logic                 mem_write;
    logic [DATA_W-1:0]    data1;
    logic [DATA_W-1:0]    data2;
    logic [DATA_W-1:0]    imm;
    logic [FUNCT_W-1:0]   funct;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
  } fields_t;

  fields_t              in_f;
  fields_t              q;
  logic                 raw_hz;
  logic [COUNT_W-1:0]   stall_cnt;
  logic [COUNT_W-1:0]   bubble_cnt;

  assign in_f = {valid_i, ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i,
                 MemWrite_i, data1_i, data2_i, imm_i, funct_i,
                 RS1addr_i, RS2addr_i, RDaddr_i};

  // A load in EX whose destination is read by the instruction in decode; x0 never conflicts.
  assign raw_hz = q.valid & q.mem_read & (q.rd != '0) & valid_i &
                  ((use_rs1_i & (RS1addr_i == q.rd)) | (use_rs2_i & (RS2addr_i == q.rd)));
  assign hazard_o = raw_hz & ~flush_i;

  // Priority: reset > flush > stall > load-use bubble > normal load.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      q          <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (flush_i) begin
      q <= '0;
    end else if (stall_i) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + COUNT_W'(1);
    end else if (raw_hz) begin
      q <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + COUNT_W'(1);
    end else begin
      q <= in_f;
    end
  end

  assign valid_o      = q.valid;
  assign ALUOp_o      = q.alu_op;
  assign ALUSrc_o     = q.alu_src;
  assign RegWrite_o   = q.reg_write;
  assign MemtoReg_o   = q.mem_to_reg;
  assign MemRead_o    = q.mem_read;
  assign MemWrite_o   = q.mem_write;
  assign data1_o      = q.data1;
  assign data2_o      = q.data2;
  assign imm_o        = q.imm;
  assign funct_o      = q.funct;
  assign RS1addr_o    = q.rs1;
  assign RS2addr_o    = q.rs2;
  assign RDaddr_o     = q.rd;
  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: a driver issues directed cycles and queues
// hand-computed expectations; a monitor pops and compares each cycle's response.
module tb_idex_stage_reg;

  localparam int CW = 2;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic        alusrc, regw, m2r, mrd, mwr;
    logic [31:0] d1, d2, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;
  } fld_t;

  typedef struct packed {
    logic rst, stall, flush, use1, use2;
    fld_t f;
  } in_t;

  typedef enum logic [1:0] {K_LOAD, K_HOLD, K_ZERO} kind_e;

  typedef struct {
    string      name;
    logic       hz;
    fld_t       f;
    logic [1:0] sc, bc;
  } exp_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  in_t cur = '0;
  logic [1:0]  alu_op_o;
  logic        alu_src_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o;
  logic [31:0] data1_o, data2_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        valid_o, hazard_o;
  logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

  idex_stage_reg #(.COUNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(cur.rst), .stall_i(cur.stall), .flush_i(cur.flush),
    .valid_i(cur.f.valid), .use_rs1_i(cur.use1), .use_rs2_i(cur.use2),
    .ALUOp_i(cur.f.aluop), .ALUSrc_i(cur.f.alusrc), .RegWrite_i(cur.f.regw),
    .MemtoReg_i(cur.f.m2r), .MemRead_i(cur.f.mrd), .MemWrite_i(cur.f.mwr),
    .data1_i(cur.f.d1), .data2_i(cur.f.d2), .imm_i(cur.f.imm), .funct_i(cur.f.funct),
    .RS1addr_i(cur.f.rs1), .RS2addr_i(cur.f.rs2), .RDaddr_i(cur.f.rd),
    .ALUOp_o(alu_op_o), .ALUSrc_o(alu_src_o), .RegWrite_o(reg_write_o),
    .MemtoReg_o(mem_to_reg_o), .MemRead_o(mem_read_o), .MemWrite_o(mem_write_o),
    .data1_o(data1_o), .data2_o(data2_o), .imm_o(imm_o), .funct_o(funct_o),
    .RS1addr_o(rs1_o), .RS2addr_o(rs2_o), .RDaddr_o(rd_o),
    .valid_o(valid_o), .hazard_o(hazard_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_busy = 1'b0;
  fld_t last_f   = '0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic in_t mk(input logic v, input logic [4:0] rs1, rs2, rd,
                             input logic mrd, u1, u2,
                             input logic [31:0] d1, d2, imm);
    in_t t;
    t         = '0;
    t.use1    = u1;
    t.use2    = u2;
    t.f.valid = v;
    t.f.aluop = mrd ? 2'b00 : 2'b10;
    t.f.alusrc = mrd | (imm != 0);
    t.f.regw  = v;
    t.f.m2r   = mrd;
    t.f.mrd   = mrd;
    t.f.funct = mrd ? 10'h002 : 10'h000;
    t.f.d1 = d1; t.f.d2 = d2; t.f.imm = imm;
    t.f.rs1 = rs1; t.f.rs2 = rs2; t.f.rd = rd;
    return t;
  endfunction

  // Apply one cycle of stimulus and queue the response expected for it.
  task automatic step(input string name, input in_t vin, input logic rst, stall, flush,
                      input kind_e k, input logic hz, input logic [1:0] sc, bc);
    exp_t e;
    @(negedge clk_i);
    cur       = vin;
    cur.rst   = rst;
    cur.stall = stall;
    cur.flush = flush;
    e.name = name;
    e.hz   = hz;
    e.sc   = sc;
    e.bc   = bc;
    case (k)
      K_LOAD:  e.f = vin.f;
      K_HOLD:  e.f = last_f;
      default: e.f = '0;
    endcase
    last_f = e.f;
    exp_q.push_back(e);
  endtask

  // Monitor: hazard_o sampled mid-cycle before the edge, registers just after it.
  initial begin
    exp_t e;
    logic hz_act;
    fld_t a;
    forever begin
      @(negedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        mon_busy = 1'b1;
        e = exp_q.pop_front();
        hz_act = hazard_o;
        @(posedge clk_i);
        #1;
        a = {valid_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o, mem_read_o,
             mem_write_o, data1_o, data2_o, imm_o, funct_o, rs1_o, rs2_o, rd_o};
        check({e.name, " hazard_o"},     160'(hz_act),      160'(e.hz));
        check({e.name, " fields"},       160'(a),           160'(e.f));
        check({e.name, " stall_cnt_o"},  160'(stall_cnt_o), 160'(e.sc));
        check({e.name, " bubble_cnt_o"}, 160'(bubble_cnt_o), 160'(e.bc));
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t idle, ld5, lw7, add1, lwx0, add3, addi4, add1_nv;
    idle    = '0;
    ld5     = mk(1, 0, 0, 5, 0, 0, 0, 32'h11, 32'h22, 0);
    lw7     = mk(1, 2, 0, 7, 1, 1, 0, 32'h100, 0, 4);
    add1    = mk(1, 7, 2, 1, 0, 1, 1, 0, 32'h22, 0);
    lwx0    = mk(1, 0, 0, 0, 1, 1, 0, 32'h0, 0, 8);
    add3    = mk(1, 0, 0, 3, 0, 1, 1, 0, 0, 0);
    addi4   = mk(1, 3, 7, 4, 0, 1, 0, 32'h33, 32'h77, 32'hFFFF_FFF0);
    add1_nv = add1;
    add1_nv.f.valid = 1'b0;

    step("reset0",        idle,  1, 0, 0, K_ZERO, 0, 0, 0);
    step("reset1",        idle,  1, 0, 0, K_ZERO, 0, 0, 0);
    step("load_rd5",      ld5,   0, 0, 0, K_LOAD, 0, 0, 0);
    step("load_lw7",      lw7,   0, 0, 0, K_LOAD, 0, 0, 0);
    step("loaduse_bub",   add1,  0, 0, 0, K_ZERO, 1, 0, 1);
    step("loaduse_add",   add1,  0, 0, 0, K_LOAD, 0, 0, 1);
    step("load_lwx0",     lwx0,  0, 0, 0, K_LOAD, 0, 0, 1);
    step("x0_no_hz",      add3,  0, 0, 0, K_LOAD, 0, 0, 1);
    step("load_lw7b",     lw7,   0, 0, 0, K_LOAD, 0, 0, 1);
    step("rs2_unused",    addi4, 0, 0, 0, K_LOAD, 0, 0, 1);
    step("load_lw7c",     lw7,   0, 0, 0, K_LOAD, 0, 0, 1);
    step("stall1_hz",     add1,  0, 1, 0, K_HOLD, 1, 1, 1);
    step("stall2_hz",     add1,  0, 1, 0, K_HOLD, 1, 2, 1);
    step("stall3_hz",     add1,  0, 1, 0, K_HOLD, 1, 3, 1);
    step("stall_flush",   add1,  0, 1, 1, K_ZERO, 0, 3, 1);
    step("flush_only",    ld5,   0, 0, 1, K_ZERO, 0, 3, 1);
    step("load_lw7d",     lw7,   0, 0, 0, K_LOAD, 0, 3, 1);
    step("rst_mid_hz",    add1,  1, 0, 0, K_ZERO, 1, 0, 0);
    step("after_rst",     add1,  0, 0, 0, K_LOAD, 0, 0, 0);
    step("sat1",          lw7,   0, 1, 0, K_HOLD, 0, 1, 0);
    step("sat2",          lw7,   0, 1, 0, K_HOLD, 0, 2, 0);
    step("sat3",          lw7,   0, 1, 0, K_HOLD, 0, 3, 0);
    step("sat4",          lw7,   0, 1, 0, K_HOLD, 0, 3, 0);
    step("sat5",          lw7,   0, 1, 0, K_HOLD, 0, 3, 0);
    step("sat6",          lw7,   0, 1, 0, K_HOLD, 0, 3, 0);
    step("load_lw7e",     lw7,   0, 0, 0, K_LOAD, 0, 3, 0);
    step("invalid_no_hz", add1_nv, 0, 0, 0, K_LOAD, 0, 3, 0);
    step("idle",          idle,  0, 0, 0, K_LOAD, 0, 3, 0);

    for (int i = 0; i < 8 && (exp_q.size() != 0 || mon_busy); i++) @(negedge clk_i);
    if (exp_q.size() != 0 || mon_busy) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
